// File: rtl/lsu_mem_seq_if.sv
// Bundles for the MEM-stage load/store sequencer: pipeline-side
// request/response channel and the word-wide data-memory port.
interface lsu_req_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_seq.sv
// MEM-stage load/store sequencer: one outstanding word access at a time,
// word-crossing accesses split in two, load data merged and extended.
module lsu_mem_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter bit SPLIT_EN   = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t state, state_n;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata0_q;

    logic                  c_we;
    logic [2:0]            c_f3;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_wdata;
    logic [1:0]            off;
    logic [7:0]            ones;
    logic [7:0]            m8;
    logic                  split;
    logic [63:0]           w64;
    logic [ADDR_WIDTH-1:0] wa0;
    logic [ADDR_WIDTH-1:0] wa1;
    logic [31:0]           r0;
    logic [31:0]           r32;
    logic [31:0]           ext;
    logic                  ld0;
    logic                  err_n;
    logic                  fin;

    // In IDLE the live request feeds the decode so REQ0 outputs are ready
    // in the cycle right after accept.
    always_comb begin
        c_we    = we_q;
        c_f3    = f3_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state == IDLE) begin
            c_we    = req.req_we;
            c_f3    = req.req_funct3;
            c_addr  = req.req_addr;
            c_wdata = req.req_wdata;
        end
        off = c_addr[1:0];
        unique case (1'b1)
            (c_f3[1:0] == 2'b00): ones = 8'h01;
            (c_f3[1:0] == 2'b01): ones = 8'h03;
            default:              ones = 8'h0f;
        endcase
        m8    = ones << off;
        split = |m8[7:4];
        w64   = {32'b0, c_wdata} << {off, 3'b000};
        wa0   = {c_addr[ADDR_WIDTH-1:2], 2'b00};
        wa1   = wa0 + ADDR_WIDTH'(4);
    end

    always_comb begin
        r0  = (state == WAIT0) ? mem.mem_rdata : rdata0_q;
        r32 = 32'({mem.mem_rdata, r0} >> {off, 3'b000});
        unique case (1'b1)
            (c_f3[1:0] == 2'b00):
                ext = c_f3[2] ? {24'b0, r32[7:0]}
                              : {{24{r32[7]}}, r32[7:0]};
            (c_f3[1:0] == 2'b01):
                ext = c_f3[2] ? {16'b0, r32[15:0]}
                              : {{16{r32[15]}}, r32[15:0]};
            default:
                ext = r32;
        endcase
    end

    always_comb begin
        state_n = state;
        ld0     = 1'b0;
        err_n   = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req.req_valid) begin
                    if (split && !SPLIT_EN) begin
                        state_n = RESP;
                        err_n   = 1'b1;
                    end else begin
                        state_n = REQ0;
                    end
                end
            end
            REQ0: if (mem.mem_gnt) state_n = WAIT0;
            WAIT0: begin
                if (mem.mem_rvalid) begin
                    ld0 = 1'b1;
                    if (split) begin
                        state_n = REQ1;
                    end else begin
                        state_n = RESP;
                        fin     = 1'b1;
                    end
                end
            end
            REQ1: if (mem.mem_gnt) state_n = WAIT1;
            WAIT1: begin
                if (mem.mem_rvalid) begin
                    state_n = RESP;
                    fin     = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q           <= 1'b0;
            f3_q           <= 3'b0;
            addr_q         <= '0;
            wdata_q        <= 32'b0;
            rdata0_q       <= 32'b0;
            req.req_ready  <= 1'b1;
            req.resp_valid <= 1'b0;
            req.resp_err   <= 1'b0;
            req.resp_rdata <= 32'b0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_be     <= 4'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= 32'b0;
        end else begin
            if (state == IDLE && req.req_valid) begin
                we_q    <= req.req_we;
                f3_q    <= req.req_funct3;
                addr_q  <= req.req_addr;
                wdata_q <= req.req_wdata;
            end
            if (ld0) rdata0_q <= mem.mem_rdata;
            req.req_ready  <= (state_n == IDLE);
            req.resp_valid <= (state_n == RESP);
            req.resp_err   <= err_n;
            req.resp_rdata <= (fin && !c_we) ? ext : 32'b0;
            mem.mem_req    <= (state_n == REQ0) || (state_n == REQ1);
            mem.mem_we     <= 1'b0;
            mem.mem_be     <= 4'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= 32'b0;
            if (state_n == REQ0) begin
                mem.mem_we    <= c_we;
                mem.mem_be    <= m8[3:0];
                mem.mem_addr  <= wa0;
                mem.mem_wdata <= w64[31:0];
            end
            if (state_n == REQ1) begin
                mem.mem_we    <= c_we;
                mem.mem_be    <= m8[7:4];
                mem.mem_addr  <= wa1;
                mem.mem_wdata <= w64[63:32];
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_seq.sv
// Directed bench for lsu_mem_seq: vector table through a split-capable
// instance plus hand sequences for rejection, delays and mid-flight reset.
module tb_lsu_mem_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cur_id = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_req_if #(.ADDR_WIDTH(32)) rq ();
    lsu_mem_if #(.ADDR_WIDTH(32)) mm ();
    lsu_req_if #(.ADDR_WIDTH(32)) rq_ns ();
    lsu_mem_if #(.ADDR_WIDTH(32)) mm_ns ();

    lsu_mem_seq #(.ADDR_WIDTH(32), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(rq.slave), .mem(mm.master)
    );
    lsu_mem_seq #(.ADDR_WIDTH(32), .SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req(rq_ns.slave), .mem(mm_ns.master)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        split;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        bit          spur;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (id %0d): got %h, expected %h",
                     nm, cur_id, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        rq.req_valid  = 1'b1;
        rq.req_we     = v.we;
        rq.req_funct3 = v.f3;
        rq.req_addr   = v.addr;
        rq.req_wdata  = v.wdata;
    endtask

    task automatic do_txn(input vec_t v);
        int t0;
        int n;
        int acc;
        @(negedge clk);
        chk("ready", rq.req_ready, 1);
        drive_req(v);
        @(negedge clk);
        rq.req_valid = 1'b0;
        t0  = cyc;
        acc = v.split ? 2 : 1;
        for (int k = 0; k < acc; k++) begin
            n = 0;
            while (!mm.mem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("mem_req", mm.mem_req, 1);
            chk("mem_addr", mm.mem_addr, k ? v.a1 : v.a0);
            chk("mem_be", mm.mem_be, k ? v.be1 : v.be0);
            chk("mem_we", mm.mem_we, v.we);
            if (v.we) chk("mem_wdata", mm.mem_wdata, k ? v.wd1 : v.wd0);
            for (int i = 0; i < v.gd; i++) begin
                mm.mem_rvalid = v.spur && k == 0 && i == 0;
                mm.mem_rdata  = 32'hBAD0_BAD0;
                @(negedge clk);
                mm.mem_rvalid = 1'b0;
                chk("hold_req", mm.mem_req, 1);
                chk("hold_addr", mm.mem_addr, k ? v.a1 : v.a0);
                chk("hold_be", mm.mem_be, k ? v.be1 : v.be0);
            end
            mm.mem_gnt = 1'b1;
            @(negedge clk);
            mm.mem_gnt = 1'b0;
            chk("req_drop", mm.mem_req, 0);
            for (int i = 1; i < v.rd; i++) @(negedge clk);
            mm.mem_rvalid = 1'b1;
            mm.mem_rdata  = k ? v.w1 : v.w0;
            @(negedge clk);
            mm.mem_rvalid = 1'b0;
        end
        n = 0;
        while (!rq.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid", rq.resp_valid, 1);
        chk("resp_rdata", rq.resp_rdata, v.rdata);
        chk("resp_err", rq.resp_err, 0);
        // t0 is sampled in cycle t+1 (accept cycle is t)
        if (v.gd == 0 && v.rd == 1)
            chk("latency", cyc - t0 + 1, v.split ? 5 : 3);
        @(negedge clk);
        chk("resp_pulse", rq.resp_valid, 0);
        chk("ready_back", rq.req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 1'b0, 4'b1000, 4'b0000, 32'h1000, 32'h0, 32'h0, 32'h0, 32'hFFFFFF80, 0, 1, 1'b0};
        vt[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 32'h0, 1'b0, 4'b1000, 4'b0000, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h00000080, 0, 1, 1'b0};
        vt[2]  = '{1'b0, 3'b001, 32'h2003, 32'h0, 32'hAB000000, 32'h000000F1, 1'b1, 4'b1000, 4'b0001, 32'h2000, 32'h2004, 32'h0, 32'h0, 32'hFFFFF1AB, 0, 1, 1'b0};
        vt[3]  = '{1'b1, 3'b010, 32'h3001, 32'h11223344, 32'h0, 32'h0, 1'b1, 4'b1110, 4'b0001, 32'h3000, 32'h3004, 32'h22334400, 32'h00000011, 32'h0, 0, 1, 1'b0};
        vt[4]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h55667788, 32'h11223344, 1'b1, 4'b1100, 4'b0011, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h33445566, 0, 1, 1'b0};
        vt[5]  = '{1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 4'b0000, 32'h40, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0};
        vt[6]  = '{1'b0, 3'b101, 32'h42, 32'h0, 32'h80010000, 32'h0, 1'b0, 4'b1100, 4'b0000, 32'h40, 32'h0, 32'h0, 32'h0, 32'h00008001, 0, 1, 1'b0};
        vt[7]  = '{1'b0, 3'b001, 32'h42, 32'h0, 32'h80010000, 32'h0, 1'b0, 4'b1100, 4'b0000, 32'h40, 32'h0, 32'h0, 32'h0, 32'hFFFF8001, 0, 1, 1'b0};
        vt[8]  = '{1'b1, 3'b000, 32'h53, 32'h000000A5, 32'h0, 32'h0, 1'b0, 4'b1000, 4'b0000, 32'h50, 32'h0, 32'hA5000000, 32'h0, 32'h0, 0, 1, 1'b0};
        vt[9]  = '{1'b1, 3'b001, 32'h62, 32'h0000BEEF, 32'h0, 32'h0, 1'b0, 4'b1100, 4'b0000, 32'h60, 32'h0, 32'hBEEF0000, 32'h0, 32'h0, 0, 1, 1'b0};
        vt[10] = '{1'b0, 3'b110, 32'h70, 32'h0, 32'h80000001, 32'h0, 1'b0, 4'b1111, 4'b0000, 32'h70, 32'h0, 32'h0, 32'h0, 32'h80000001, 0, 1, 1'b0};
        vt[11] = '{1'b0, 3'b000, 32'h81, 32'h0, 32'h00007F00, 32'h0, 1'b0, 4'b0010, 4'b0000, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0000007F, 0, 1, 1'b0};
        vt[12] = '{1'b0, 3'b010, 32'h90, 32'h0, 32'h12345678, 32'h0, 1'b0, 4'b1111, 4'b0000, 32'h90, 32'h0, 32'h0, 32'h0, 32'h12345678, 3, 2, 1'b1};
        vt[13] = '{1'b1, 3'b001, 32'hA3, 32'h0000CAFE, 32'h0, 32'h0, 1'b1, 4'b1000, 4'b0001, 32'hA0, 32'hA4, 32'hFE000000, 32'h000000CA, 32'h0, 2, 3, 1'b1};

        rst_n = 1'b0;
        rq.req_valid = 1'b0;    rq.req_we = 1'b0;     rq.req_funct3 = 3'b0;
        rq.req_addr = 32'h0;    rq.req_wdata = 32'h0;
        mm.mem_gnt = 1'b0;      mm.mem_rvalid = 1'b1; mm.mem_rdata = 32'h0;
        rq_ns.req_valid = 1'b0; rq_ns.req_we = 1'b0;  rq_ns.req_funct3 = 3'b0;
        rq_ns.req_addr = 32'h0; rq_ns.req_wdata = 32'h0;
        mm_ns.mem_gnt = 1'b0;   mm_ns.mem_rvalid = 1'b0; mm_ns.mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_ready", rq.req_ready, 1);
        chk("rst_resp_valid", rq.resp_valid, 0);
        chk("rst_resp_err", rq.resp_err, 0);
        chk("rst_resp_rdata", rq.resp_rdata, 0);
        chk("rst_mem_req", mm.mem_req, 0);
        chk("rst_mem_we", mm.mem_we, 0);
        chk("rst_mem_be", mm.mem_be, 0);
        chk("rst_mem_addr", mm.mem_addr, 0);
        chk("rst_mem_wdata", mm.mem_wdata, 0);
        chk("rst_ns_ready", rq_ns.req_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        mm.mem_rvalid = 1'b0;
        chk("stale_rvalid", rq.resp_valid, 0);
        chk("stale_ready", rq.req_ready, 1);

        for (int i = 0; i < 14; i++) begin
            cur_id = i;
            do_txn(vt[i]);
        end

        // rejected word-crossing lw on the non-splitting instance
        cur_id = 100;
        @(negedge clk);
        rq_ns.req_valid = 1'b1; rq_ns.req_we = 1'b0;
        rq_ns.req_funct3 = 3'b010; rq_ns.req_addr = 32'hFFFFFFFE;
        @(negedge clk);
        rq_ns.req_valid = 1'b0;
        chk("ns_resp_valid", rq_ns.resp_valid, 1);
        chk("ns_resp_err", rq_ns.resp_err, 1);
        chk("ns_resp_rdata", rq_ns.resp_rdata, 0);
        chk("ns_no_req", mm_ns.mem_req, 0);
        chk("ns_busy", rq_ns.req_ready, 0);
        @(negedge clk);
        chk("ns_pulse", rq_ns.resp_valid, 0);
        chk("ns_ready", rq_ns.req_ready, 1);
        chk("ns_no_req2", mm_ns.mem_req, 0);

        // aligned store still served without splitting
        cur_id = 101;
        rq_ns.req_valid = 1'b1; rq_ns.req_we = 1'b1;
        rq_ns.req_funct3 = 3'b010; rq_ns.req_addr = 32'h10;
        rq_ns.req_wdata = 32'h11223344;
        @(negedge clk);
        rq_ns.req_valid = 1'b0;
        chk("ns_mem_req", mm_ns.mem_req, 1);
        chk("ns_mem_be", mm_ns.mem_be, 4'b1111);
        chk("ns_mem_addr", mm_ns.mem_addr, 32'h10);
        chk("ns_mem_wdata", mm_ns.mem_wdata, 32'h11223344);
        mm_ns.mem_gnt = 1'b1;
        @(negedge clk);
        mm_ns.mem_gnt = 1'b0;
        mm_ns.mem_rvalid = 1'b1;
        @(negedge clk);
        mm_ns.mem_rvalid = 1'b0;
        chk("ns_st_resp", rq_ns.resp_valid, 1);
        chk("ns_st_err", rq_ns.resp_err, 0);

        // reset while waiting for the second half of a split load
        cur_id = 200;
        @(negedge clk);
        drive_req(vt[2]);
        @(negedge clk);
        rq.req_valid = 1'b0;
        mm.mem_gnt = 1'b1;
        @(negedge clk);
        mm.mem_gnt = 1'b0;
        mm.mem_rvalid = 1'b1; mm.mem_rdata = 32'hAB000000;
        @(negedge clk);
        mm.mem_rvalid = 1'b0;
        chk("r6_req1", mm.mem_req, 1);
        chk("r6_addr1", mm.mem_addr, 32'h2004);
        mm.mem_gnt = 1'b1;
        @(negedge clk);
        mm.mem_gnt = 1'b0;
        chk("r6_wait1", mm.mem_req, 0);
        rst_n = 1'b0;
        #1;
        chk("r6_ready", rq.req_ready, 1);
        chk("r6_resp_valid", rq.resp_valid, 0);
        chk("r6_mem_be", mm.mem_be, 0);
        chk("r6_mem_addr", mm.mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mm.mem_rvalid = 1'b1; mm.mem_rdata = 32'h000000F1;
        @(negedge clk);
        mm.mem_rvalid = 1'b0;
        chk("r6_late_rvalid", rq.resp_valid, 0);
        chk("r6_idle", rq.req_ready, 1);
        @(negedge clk);
        chk("r6_no_resp", rq.resp_valid, 0);
        chk("r6_no_req", mm.mem_req, 0);

        // reset while a request is on the memory port drops mem_req at once
        cur_id = 201;
        drive_req(vt[5]);
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("r7_req", mm.mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("r7_async_drop", mm.mem_req, 0);
        chk("r7_ready", rq.req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        cur_id = 202;
        do_txn(vt[5]);
        cur_id = 203;
        do_txn(vt[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
